inval_line_scheduler: RTL and testbench
=======================================

# inval_line_scheduler

Buffers and schedules cache-line invalidation requests between the AXI invalidation filter (producer) and CVA6's L1 data-cache invalidation port (consumer) in the Ara system. Decouples filter throughput from L1 back-pressure with a small FIFO of line-aligned addresses. Optionally drops requests whose line is already queued, so each line is sent to the L1 only once. Sits inside the system wrapper, between the filter's `inval_*_o` and the core's `inval_*_i`.

## Interface
- `AddrWidth`, 64: address width in bits.
- `L1LineWidth`, 16: L1 line size in bytes; a power of two, at least 2.
- `Depth`, 4: number of queue entries; a power of two, at least 2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `en_i` in 1: coherence enable (the core's `acc_cons_en`).
- `inval_addr_i` in AddrWidth: invalidation byte address from the filter.
- `inval_valid_i` in 1: request valid from the filter.
- `inval_ready_o` out 1: request accepted by this block.
- `inval_addr_o` out AddrWidth: line-aligned address to the L1.
- `inval_valid_o` out 1: request valid to the L1.
- `inval_ready_i` in 1: L1 accepted the request.
- `idle_o` out 1: queue is empty and no input handshake occurs this cycle.

## Operation
- **Line alignment.** `line = inval_addr_i & ~(L1LineWidth-1)`. Only line addresses are stored.
- **Queue structure.** Circular FIFO with `Depth` entries.
  - Write and read pointers are `$clog2(Depth)` bits wide and wrap modulo `Depth`.
  - An occupancy counter is `$clog2(Depth)+1` bits wide.
  - Each entry has a valid bit.
- **Input ready.** `inval_ready_o = !full`.
- **Input handshake** (`inval_valid_i && inval_ready_o`):
  - If `en_i` = 0: the request is accepted and discarded; queue state is unchanged.
  - If `en_i` = 1 and the request merges (see Configuration): accepted and discarded.
  - Otherwise: `line` is written at the write pointer, the write pointer increments, and the count increments.
- **Output.** `inval_valid_o = !empty`. `inval_addr_o = entry[rd_ptr]`.
- **Output handshake** (`inval_valid_o && inval_ready_i`): the read pointer increments and the count decrements.
- **Push and pop in the same cycle.** The count is unchanged. This is allowed whenever the queue is not full.
- **Full.** Input ready is low. A pop in the same cycle does not raise `inval_ready_o` combinationally; the input is accepted from the next cycle.
- **Empty.** Output valid is low. An input push becomes visible on the output the following cycle; there is no bypass path.
- **Drain while disabled.** `en_i` falling does not flush the queue. Entries already queued still drain to the L1.
- **Reset mid-operation.** All queued entries are lost. Pointers and count return to 0.

## Timing
- Values after reset:
  - `inval_valid_o` = 0
  - `inval_addr_o` = 0
  - `inval_ready_o` = 1
  - `idle_o` = 1
  - pointers, count and entry valid bits = 0
- Input-to-output latency: 1 cycle (push at cycle N, `inval_valid_o` high at N+1).
- Throughput: 1 request per cycle in each direction.
- `inval_addr_o` is stable while `inval_valid_o && !inval_ready_i`. `inval_valid_o` does not deassert without a handshake, except on reset.
- `inval_ready_o` depends only on registered state; it has no combinational path from `inval_valid_i` or `inval_ready_i`.
- `idle_o` is combinational: `empty && !(inval_valid_i && inval_ready_o)`.

## Configuration
- Macro: `INVAL_SCHED_MERGE_EN`.
- **Defined:**
  - An input line that equals any valid queued entry is merged, i.e. accepted and dropped.
  - Exception: the head entry is excluded from the comparison in a cycle where it is being popped. In that case the request is enqueued normally, because the L1 may already have performed that invalidation.
  - The comparison uses registered entries only.
- **Undefined:** no comparators are instantiated; every enabled request is enqueued (pure FIFO).

## Test plan
- **Reset and single request.** Reset, then `en_i`=1 and push `0x8000_0013` with `inval_ready_i`=1.
  - Required: `inval_valid_o` high exactly 1 cycle later with `inval_addr_o`=`0x8000_0010`; `idle_o` returns to 1.
- **Fill and back-pressure.** `inval_ready_i`=0; push lines `0x100`, `0x200`, `0x300`, `0x400`.
  - Required: `inval_ready_o`=0 after the 4th push; a 5th request is held.
  - Then raise `inval_ready_i`: output order is `0x100`…`0x400`, and the held request is accepted one cycle after the first pop.
- **Merge** (macro defined). `inval_ready_i`=0; push `0x100`, `0x104`, `0x200`.
  - Required: the queue holds 2 entries; the output sequence is `0x100`, `0x200`.
  - With the macro undefined: 3 entries; the output sequence is `0x100`, `0x100`, `0x200`.
- **Head-pop race** (macro defined). Head=`0x100` popping this cycle; push `0x108` in the same cycle.
  - Required: `0x100` is enqueued again and appears on the output twice.
- **Disabled.** `en_i`=0; push 3 requests.
  - Required: all accepted, `inval_valid_o` stays 0, `idle_o` stays 0 only in the handshake cycles.
  - Then deassert `en_i` while 2 entries are queued: both still drain.
- **Reset mid-operation.** Assert `rst_ni`=0 with 3 entries queued.
  - Required: `inval_valid_o`=0 immediately (asynchronous); after release, the queue is empty and `inval_ready_o`=1.

Source files
------------

// File: rtl/inval_line_scheduler.sv
// Line-aligned invalidation queue between the AXI invalidation filter and the L1 D-cache.
// Optional duplicate-line merging is enabled by defining INVAL_SCHED_MERGE_EN.
module inval_line_scheduler #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter int unsigned Depth       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [AddrWidth-1:0] inval_addr_i,
  input  logic                 inval_valid_i,
  output logic                 inval_ready_o,
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 inval_valid_o,
  input  logic                 inval_ready_i,
  output logic                 idle_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(L1LineWidth - 1));

  logic [AddrWidth-1:0] entry_q [Depth];
  logic [Depth-1:0]     entry_vld_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic [AddrWidth-1:0] line;
  logic                 full;
  logic                 empty;
  logic                 in_hs;
  logic                 pop;
  logic                 push;
  logic                 merge_hit;

  assign line  = inval_addr_i & LineMask;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  // Ready comes only from registered occupancy, so a same-cycle pop never opens a full queue.
  assign inval_ready_o = !full;
  assign in_hs         = inval_valid_i && !full;

  assign inval_valid_o = !empty;
  assign inval_addr_o  = entry_q[rd_ptr_q];
  assign pop           = !empty && inval_ready_i;

  assign idle_o = empty && !in_hs;

`ifdef INVAL_SCHED_MERGE_EN
  // A head being popped may already be invalidated in the L1, so it cannot absorb a new request.
  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (entry_vld_q[i] && (entry_q[i] == line) && !(pop && (rd_ptr_q == PtrW'(i)))) begin
        merge_hit = 1'b1;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign push = in_hs && en_i && !merge_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      entry_vld_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr_q              <= rd_ptr_q + 1'b1;
        entry_vld_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        entry_q[wr_ptr_q]     <= line;
        entry_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inval_line_scheduler.sv
// Directed bench for inval_line_scheduler: expected lines are queued on stimulus and
// compared against every output handshake; works with or without INVAL_SCHED_MERGE_EN.
module tb_inval_line_scheduler;

  logic        clk_i;
  logic        rst_ni;
  logic        en_i;
  logic [63:0] inval_addr_i;
  logic        inval_valid_i;
  logic        inval_ready_o;
  logic [63:0] inval_addr_o;
  logic        inval_valid_o;
  logic        inval_ready_i;
  logic        idle_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];

  inval_line_scheduler #(
    .AddrWidth  (64),
    .L1LineWidth(16),
    .Depth      (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .inval_addr_i (inval_addr_i),
    .inval_valid_i(inval_valid_i),
    .inval_ready_o(inval_ready_o),
    .inval_addr_o (inval_addr_o),
    .inval_valid_o(inval_valid_o),
    .inval_ready_i(inval_ready_i),
    .idle_o       (idle_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [63:0] addr, input logic [63:0] exp_line, input bit enq);
    inval_valid_i = 1'b1;
    inval_addr_i  = addr;
    if (enq) sb.push_back(exp_line);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("drain_left", 64'(sb.size()), 64'd0);
    @(negedge clk_i);
    chk("drain_valid", 64'(inval_valid_o), 64'd0);
    tick();
  endtask

  // Output monitor: every L1 handshake must match the oldest expected line.
  always @(negedge clk_i) begin
    if (rst_ni && inval_valid_o && inval_ready_i) begin
      n_checks++;
      assert (sb.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_out: observed 0x%0h expected none", inval_addr_o);
      end
      if (sb.size() != 0) chk("out_addr", inval_addr_o, sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni        = 1'b0;
    en_i          = 1'b0;
    inval_valid_i = 1'b0;
    inval_addr_i  = '0;
    inval_ready_i = 1'b0;
    #12;
    @(negedge clk_i);
    chk("rst_valid", 64'(inval_valid_o), 64'd0);
    chk("rst_addr", inval_addr_o, 64'd0);
    chk("rst_ready", 64'(inval_ready_o), 64'd1);
    chk("rst_idle", 64'(idle_o), 64'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    // Single request, one-cycle latency, no bypass
    en_i = 1'b1;
    inval_ready_i = 1'b1;
    send(64'h8000_0013, 64'h8000_0010, 1'b1);
    @(negedge clk_i);
    chk("single_idle_hs", 64'(idle_o), 64'd0);
    chk("single_no_bypass", 64'(inval_valid_o), 64'd0);
    tick();
    inval_valid_i = 1'b0;
    @(negedge clk_i);
    chk("single_valid", 64'(inval_valid_o), 64'd1);
    chk("single_idle_busy", 64'(idle_o), 64'd0);
    tick();
    @(negedge clk_i);
    chk("single_idle_back", 64'(idle_o), 64'd1);
    chk("single_valid_low", 64'(inval_valid_o), 64'd0);
    tick();

    // Fill to full under back-pressure, then release
    inval_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(64'h100 * (i + 1), 64'h100 * (i + 1), 1'b1);
      @(negedge clk_i);
      chk("fill_ready", 64'(inval_ready_o), 64'd1);
      if (i > 0) chk("hold_addr", inval_addr_o, 64'h100);
      tick();
    end
    send(64'h500, 64'h500, 1'b1);
    @(negedge clk_i);
    chk("full_ready", 64'(inval_ready_o), 64'd0);
    chk("full_valid", 64'(inval_valid_o), 64'd1);
    tick();
    inval_ready_i = 1'b1;
    @(negedge clk_i);
    chk("ready_during_pop", 64'(inval_ready_o), 64'd0);
    tick();
    @(negedge clk_i);
    chk("ready_after_pop", 64'(inval_ready_o), 64'd1);
    tick();
    inval_valid_i = 1'b0;
    drain();

    // Duplicate line while queued
    inval_ready_i = 1'b0;
    send(64'h100, 64'h100, 1'b1);
    tick();
`ifdef INVAL_SCHED_MERGE_EN
    send(64'h104, 64'h100, 1'b0);
`else
    send(64'h104, 64'h100, 1'b1);
`endif
    tick();
    send(64'h200, 64'h200, 1'b1);
    tick();
    inval_valid_i = 1'b0;
    inval_ready_i = 1'b1;
    drain();

    // Same line arrives while its head copy is popping
    inval_ready_i = 1'b0;
    send(64'h100, 64'h100, 1'b1);
    tick();
    inval_ready_i = 1'b1;
    send(64'h108, 64'h100, 1'b1);
    tick();
    inval_valid_i = 1'b0;
    drain();

    // Disabled: accepted and discarded
    en_i = 1'b0;
    inval_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(64'h1000 + 64'(i * 16), 64'h0, 1'b0);
      @(negedge clk_i);
      chk("dis_idle_hs", 64'(idle_o), 64'd0);
      chk("dis_valid", 64'(inval_valid_o), 64'd0);
      chk("dis_ready", 64'(inval_ready_o), 64'd1);
      tick();
    end
    inval_valid_i = 1'b0;
    @(negedge clk_i);
    chk("dis_idle_after", 64'(idle_o), 64'd1);
    chk("dis_valid_after", 64'(inval_valid_o), 64'd0);
    tick();

    // Entries queued before disabling still drain
    en_i = 1'b1;
    inval_ready_i = 1'b0;
    send(64'h600, 64'h600, 1'b1);
    tick();
    send(64'h700, 64'h700, 1'b1);
    tick();
    inval_valid_i = 1'b0;
    en_i = 1'b0;
    @(negedge clk_i);
    chk("dis_drain_valid", 64'(inval_valid_o), 64'd1);
    tick();
    inval_ready_i = 1'b1;
    drain();

    // Asynchronous reset with entries queued
    en_i = 1'b1;
    inval_ready_i = 1'b0;
    send(64'hA00, 64'hA00, 1'b1);
    tick();
    send(64'hB00, 64'hB00, 1'b1);
    tick();
    send(64'hC00, 64'hC00, 1'b1);
    tick();
    inval_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_valid", 64'(inval_valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 64'(inval_valid_o), 64'd0);
    chk("async_rst_ready", 64'(inval_ready_o), 64'd1);
    chk("async_rst_addr", inval_addr_o, 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", 64'(inval_valid_o), 64'd0);
    chk("post_rst_ready", 64'(inval_ready_o), 64'd1);
    chk("post_rst_idle", 64'(idle_o), 64'd1);
    tick();
    inval_ready_i = 1'b1;
    send(64'hD05, 64'hD00, 1'b1);
    tick();
    inval_valid_i = 1'b0;
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
